count_display_monitor: RTL

Downstream consumer of the 4-bit mode-controlled counter. It samples the counter's control input `A` and count `Z` every clock and drives a multiplexed two-digit seven-segment display showing `Z` in decimal (0–15). It also runs a cycle-accurate checker that flags any `Z` transition the counter rules do not allow. It sits between the counter and the board display/LED pins.

---
 rtl/count_display_monitor.sv | 115 +++++++++++
 1 files changed

// File: rtl/count_display_monitor.sv
// Seven-segment display driver and transition checker for the 4-bit mode-controlled counter.
// Checker, err and err_cnt are compiled only when MONITOR_CHECK_EN is defined.
module count_display_monitor #(
    parameter int unsigned SCAN_DIV  = 16,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           A,
    input  logic [3:0]           Z,
    output logic [6:0]           seg,
    output logic [1:0]           an,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    logic [3:0]  z_q;
    logic [15:0] div;
    logic        dsel;
    logic        tens;
    logic [3:0]  ones;

    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h40;
            4'd1:    p = 7'h79;
            4'd2:    p = 7'h24;
            4'd3:    p = 7'h30;
            4'd4:    p = 7'h19;
            4'd5:    p = 7'h12;
            4'd6:    p = 7'h02;
            4'd7:    p = 7'h78;
            4'd8:    p = 7'h00;
            4'd9:    p = 7'h10;
            default: p = 7'h7F;
        endcase
        return p;
    endfunction

    always_comb begin
        tens = (z_q >= 4'd10);
        ones = z_q - (tens ? 4'd10 : 4'd0);
    end

    // Display uses the previous z_q, giving the two-edge Z-to-segment latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            z_q  <= '0;
            div  <= '0;
            dsel <= 1'b0;
            seg  <= 7'h7F;
            an   <= 2'b11;
        end else begin
            z_q <= Z;
            if (div == 16'(SCAN_DIV - 1)) begin
                div  <= '0;
                dsel <= ~dsel;
            end else begin
                div <= div + 16'd1;
            end
            if (!dsel) begin
                an  <= 2'b10;
                seg <= seg_pat(ones);
            end else if (tens) begin
                an  <= 2'b01;
                seg <= seg_pat(4'd1);
            end else begin
                an  <= 2'b11;
                seg <= 7'h7F;
            end
        end
    end

`ifdef MONITOR_CHECK_EN
    logic [1:0] a_q;
    logic       v_q;
    logic [3:0] exp_z;
    logic       mismatch;

    always_comb begin
        exp_z = z_q;
        case (a_q)
            2'b00:   exp_z = z_q[0] ? 4'd0 : z_q + 4'd2;
            2'b01:   exp_z = z_q[0] ? z_q + 4'd2 : 4'd1;
            2'b10:   exp_z = 4'hF;
            default: exp_z = z_q;
        endcase
        mismatch = v_q && (Z != exp_z);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            v_q     <= 1'b0;
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            a_q <= A;
            v_q <= 1'b1;
            if (mismatch) begin
                err <= 1'b1;
                if (err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_a;
    assign unused_a = ^A;
    assign err      = 1'b0;
    assign err_cnt  = '0;
`endif

endmodule
